mux_stream_deser: RTL and testbench

Serial-to-parallel capture stage directly downstream of the 2:1 multiplexer. It samples the mux output `Y` on qualified bit strobes and assembles `WIDTH` bits LSB-first into a word. Each word is presented on a one-entry output buffer with a valid/ready handshake. The block turns the mux's single-bit data path into words a register bank or LED display driver can consume, and flags words lost to back-pressure.

---
 rtl/mux_stream_deser.sv | 146 ++++++++++++++
 tb/tb_mux_stream_deser.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_stream_deser.sv
// Serial-to-parallel capture stage behind the 2:1 mux: assembles WIDTH bits LSB-first into a one-entry valid/ready buffer.
// Optional even-parity frame bit enabled by defining MUX_DESER_PARITY_EN.
module mux_stream_deser #(
    parameter int WIDTH = 8
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         Y,
    input  logic                         Y_VLD,
    input  logic                         CLR,
    output logic [WIDTH-1:0]             DOUT,
    output logic                         DOUT_VLD,
    input  logic                         DOUT_RDY,
    output logic                         OVF,
    output logic                         PERR,
    output logic [$clog2(WIDTH+1)-1:0]   BIT_CNT
);

    localparam int CW = $clog2(WIDTH+1);

`ifdef MUX_DESER_PARITY_EN
    typedef enum logic {S_DATA, S_PAR} state_t;
`else
    typedef enum logic {S_DATA} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] dout_q, dout_n;
    logic             vld_q, vld_n;
    logic             ovf_q, ovf_n;
    logic             commit;
    logic [WIDTH-1:0] word;
`ifdef MUX_DESER_PARITY_EN
    logic             perr_q, perr_n;
    logic             par;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= S_DATA;
            shreg  <= '0;
            cnt    <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef MUX_DESER_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            cnt    <= cnt_n;
            dout_q <= dout_n;
            vld_q  <= vld_n;
            ovf_q  <= ovf_n;
`ifdef MUX_DESER_PARITY_EN
            perr_q <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        dout_n  = dout_q;
        vld_n   = vld_q;
        ovf_n   = ovf_q;
        commit  = 1'b0;
        word    = shreg;
`ifdef MUX_DESER_PARITY_EN
        perr_n  = perr_q;
        par     = 1'b0;
`endif
        if (CLR) begin
            state_n = S_DATA;
            shreg_n = '0;
            cnt_n   = '0;
            dout_n  = '0;
            vld_n   = 1'b0;
            ovf_n   = 1'b0;
`ifdef MUX_DESER_PARITY_EN
            perr_n  = 1'b0;
`endif
        end else begin
            if (vld_q && DOUT_RDY)
                vld_n = 1'b0;
            if (Y_VLD) begin
                case (state)
                    S_DATA: begin
                        for (int unsigned i = 0; i < WIDTH; i++)
                            if (CW'(i) == cnt)
                                shreg_n[i] = Y;
                        if (cnt == CW'(WIDTH-1)) begin
`ifdef MUX_DESER_PARITY_EN
                            state_n = S_PAR;
                            cnt_n   = cnt + CW'(1);
`else
                            commit  = 1'b1;
                            word    = shreg_n;
                            cnt_n   = '0;
`endif
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
`ifdef MUX_DESER_PARITY_EN
                    S_PAR: begin
                        commit  = 1'b1;
                        word    = shreg;
                        par     = (^shreg) ^ Y;
                        state_n = S_DATA;
                        cnt_n   = '0;
                    end
`endif
                    default: ;
                endcase
            end
            // A full, unaccepted buffer keeps its word; the new one is dropped and flagged.
            if (commit) begin
                if (!vld_q || DOUT_RDY) begin
                    dout_n = word;
                    vld_n  = 1'b1;
`ifdef MUX_DESER_PARITY_EN
                    perr_n = par;
`endif
                end else begin
                    ovf_n = 1'b1;
                end
            end
        end
    end

    assign DOUT     = dout_q;
    assign DOUT_VLD = vld_q;
    assign OVF      = ovf_q;
    assign BIT_CNT  = cnt;
`ifdef MUX_DESER_PARITY_EN
    assign PERR     = perr_q;
`else
    assign PERR     = 1'b0;
`endif

endmodule

// File: tb/tb_mux_stream_deser.sv
// Directed bench for mux_stream_deser (WIDTH=8); parity cases run when MUX_DESER_PARITY_EN is defined.
module tb_mux_stream_deser;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       Y;
    logic       Y_VLD;
    logic       CLR;
    logic [7:0] DOUT;
    logic       DOUT_VLD;
    logic       DOUT_RDY;
    logic       OVF;
    logic       PERR;
    logic [3:0] BIT_CNT;

    int n_chk = 0;
    int n_bad = 0;

    mux_stream_deser #(.WIDTH(8)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Y        (Y),
        .Y_VLD    (Y_VLD),
        .CLR      (CLR),
        .DOUT     (DOUT),
        .DOUT_VLD (DOUT_VLD),
        .DOUT_RDY (DOUT_RDY),
        .OVF      (OVF),
        .PERR     (PERR),
        .BIT_CNT  (BIT_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        Y_VLD = 1'b0;
        @(negedge CLK);
    endtask

    // Inputs change just after a falling edge; outputs are read at the next falling edge.
    task automatic send_word(input logic [7:0] w, input int gap, input bit rdy_last,
                             input bit bad_par, input bit chk_cnt);
`ifdef MUX_DESER_PARITY_EN
        int nb = 9;
`else
        int nb = 8;
`endif
        for (int i = 0; i < nb; i++) begin
            logic b;
            b = (i < 8) ? w[i] : ((^w) ^ bad_par);
            if (chk_cnt) begin
                check("bit_cnt_step", BIT_CNT, i);
                check("vld_early", DOUT_VLD, 0);
            end
            if (rdy_last && i == nb - 1)
                DOUT_RDY = 1'b1;
            Y     = b;
            Y_VLD = 1'b1;
            @(negedge CLK);
            Y_VLD = 1'b0;
            if (i < nb - 1)
                for (int g = 0; g < gap; g++) begin
                    Y = ~Y;
                    @(negedge CLK);
                end
        end
    endtask

    initial begin
        RST_N = 1'b0; Y = 1'b0; Y_VLD = 1'b0; CLR = 1'b0; DOUT_RDY = 1'b0;
        #12;
        check("rst_dout", DOUT, 8'h00);
        check("rst_vld", DOUT_VLD, 0);
        check("rst_ovf", OVF, 0);
        check("rst_perr", PERR, 0);
        check("rst_cnt", BIT_CNT, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        // basic word, consumer always ready
        DOUT_RDY = 1'b1;
        send_word(8'h4D, 0, 0, 0, 1);
        check("basic_dout", DOUT, 8'h4D);
        check("basic_vld", DOUT_VLD, 1);
        check("basic_ovf", OVF, 0);
        check("basic_perr", PERR, 0);
        check("basic_cnt", BIT_CNT, 0);
        idle();
        check("basic_vld_drop", DOUT_VLD, 0);
        check("basic_hold", DOUT, 8'h4D);

        // gapped strobes with Y toggling while idle
        send_word(8'h4D, 3, 0, 0, 1);
        check("gap_dout", DOUT, 8'h4D);
        check("gap_vld", DOUT_VLD, 1);
        check("gap_cnt", BIT_CNT, 0);
        idle();

        // overflow under back-pressure
        DOUT_RDY = 1'b0;
        send_word(8'hA5, 0, 0, 0, 0);
        check("ovf_first_dout", DOUT, 8'hA5);
        check("ovf_first_flag", OVF, 0);
        send_word(8'h3C, 0, 0, 0, 0);
        check("ovf_dout", DOUT, 8'hA5);
        check("ovf_vld", DOUT_VLD, 1);
        check("ovf_flag", OVF, 1);
        DOUT_RDY = 1'b1;
        idle();
        check("ovf_acc_vld", DOUT_VLD, 0);
        check("ovf_sticky", OVF, 1);
        check("ovf_acc_dout", DOUT, 8'hA5);

        // clear while idle
        CLR = 1'b1;
        idle();
        CLR = 1'b0;
        check("clr_ovf", OVF, 0);
        check("clr_vld", DOUT_VLD, 0);
        check("clr_dout", DOUT, 8'h00);

        // commit and accept on the same edge
        DOUT_RDY = 1'b0;
        send_word(8'h11, 0, 0, 0, 0);
        check("sim_first", DOUT, 8'h11);
        send_word(8'h22, 0, 1, 0, 0);
        check("sim_dout", DOUT, 8'h22);
        check("sim_vld", DOUT_VLD, 1);
        check("sim_ovf", OVF, 0);
        idle();
        check("sim_vld_drop", DOUT_VLD, 0);

        // asynchronous reset mid-frame
        for (int i = 0; i < 5; i++) begin
            Y = 1'b1; Y_VLD = 1'b1;
            @(negedge CLK);
        end
        Y_VLD = 1'b0;
        check("mid_cnt", BIT_CNT, 5);
        RST_N = 1'b0;
        #1;
        check("arst_cnt", BIT_CNT, 0);
        check("arst_dout", DOUT, 8'h00);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        send_word(8'hFF, 0, 0, 0, 0);
        check("arst_ff", DOUT, 8'hFF);
        check("arst_ff_vld", DOUT_VLD, 1);
        idle();

        // clear overrides a simultaneous strobe
        for (int i = 0; i < 3; i++) begin
            Y = 1'b1; Y_VLD = 1'b1;
            @(negedge CLK);
        end
        Y = 1'b1; Y_VLD = 1'b1; CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0; Y_VLD = 1'b0;
        check("clr_strobe_cnt", BIT_CNT, 0);
        check("clr_strobe_dout", DOUT, 8'h00);
        send_word(8'h5A, 0, 0, 0, 1);
        check("clr_next_word", DOUT, 8'h5A);
        idle();

`ifdef MUX_DESER_PARITY_EN
        send_word(8'h4D, 0, 0, 0, 0);
        check("par_ok_dout", DOUT, 8'h4D);
        check("par_ok_perr", PERR, 0);
        idle();
        send_word(8'h4D, 0, 0, 1, 0);
        check("par_bad_dout", DOUT, 8'h4D);
        check("par_bad_perr", PERR, 1);
        check("par_bad_vld", DOUT_VLD, 1);
        idle();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
